// File: rtl/buzzer_sequencer.sv
// Buzzer owner for the keypad lock: arbitrates click/pass/fail tone requests by fixed priority.
// Optional macro BUZZER_MUTE_EN adds a mute input that gates the registered buzzer drive.
module buzzer_sequencer #(
  parameter int unsigned CLICK_HALF = 50000,
  parameter int unsigned CLICK_LEN  = 10000000,
  parameter int unsigned PASS_HALF  = 25000,
  parameter int unsigned PASS_LEN   = 30000000,
  parameter int unsigned FAIL_HALF  = 100000,
  parameter int unsigned FAIL_SEG   = 5000000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_click,
  input  logic       req_pass,
  input  logic       req_fail,
`ifdef BUZZER_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] tone_id,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle, StClick, StPass, StFailB1, StFailGap, StFailB2
  } state_e;

  localparam logic [CNT_W-1:0] ClickHalfLast = CNT_W'(CLICK_HALF - 1);
  localparam logic [CNT_W-1:0] ClickLenLast  = CNT_W'(CLICK_LEN - 1);
  localparam logic [CNT_W-1:0] PassHalfLast  = CNT_W'(PASS_HALF - 1);
  localparam logic [CNT_W-1:0] PassLenLast   = CNT_W'(PASS_LEN - 1);
  localparam logic [CNT_W-1:0] FailHalfLast  = CNT_W'(FAIL_HALF - 1);
  localparam logic [CNT_W-1:0] FailSegLast   = CNT_W'(FAIL_SEG - 1);

  state_e           state_q;
  logic [CNT_W-1:0] dur_q, half_q;
  logic             buzz_q, busy_q, done_q;
  logic [1:0]       tone_id_q;

  logic [1:0]       req_pri, cur_pri;
  logic [CNT_W-1:0] half_last, dur_last;
  logic             dur_end, finishing, accept;

  always_comb begin
    req_pri = 2'd0;
    if (req_fail)       req_pri = 2'd3;
    else if (req_pass)  req_pri = 2'd2;
    else if (req_click) req_pri = 2'd1;

    half_last = '0;
    dur_last  = '0;
    unique case (state_q)
      StClick: begin
        half_last = ClickHalfLast;
        dur_last  = ClickLenLast;
      end
      StPass: begin
        half_last = PassHalfLast;
        dur_last  = PassLenLast;
      end
      StFailB1, StFailGap, StFailB2: begin
        half_last = FailHalfLast;
        dur_last  = FailSegLast;
      end
      default: ;
    endcase

    dur_end   = (state_q != StIdle) && (dur_q == dur_last);
    finishing = dur_end && (state_q inside {StClick, StPass, StFailB2});
    // A pattern ending on this edge no longer blocks lower-priority requests.
    cur_pri   = finishing ? 2'd0 : tone_id_q;
    accept    = (req_pri != 2'd0) && (req_pri >= cur_pri);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dur_q     <= '0;
      half_q    <= '0;
      buzz_q    <= 1'b0;
      busy_q    <= 1'b0;
      tone_id_q <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        unique case (req_pri)
          2'd3:    state_q <= StFailB1;
          2'd2:    state_q <= StPass;
          default: state_q <= StClick;
        endcase
        dur_q     <= '0;
        half_q    <= '0;
        buzz_q    <= 1'b1;
        busy_q    <= 1'b1;
        tone_id_q <= req_pri;
      end else if (state_q != StIdle) begin
        if (dur_end) begin
          dur_q  <= '0;
          half_q <= '0;
          unique case (state_q)
            StFailB1: begin
              state_q <= StFailGap;
              buzz_q  <= 1'b0;
            end
            StFailGap: begin
              state_q <= StFailB2;
              buzz_q  <= 1'b1;
            end
            default: begin
              state_q   <= StIdle;
              buzz_q    <= 1'b0;
              busy_q    <= 1'b0;
              tone_id_q <= 2'd0;
              done_q    <= 1'b1;
            end
          endcase
        end else begin
          dur_q <= dur_q + 1'b1;
          if (state_q == StFailGap) begin
            half_q <= '0;
          end else if (half_q == half_last) begin
            half_q <= '0;
            buzz_q <= ~buzz_q;
          end else begin
            half_q <= half_q + 1'b1;
          end
        end
      end
    end
  end

`ifdef BUZZER_MUTE_EN
  assign buzzer = buzz_q & ~mute;
`else
  assign buzzer = buzz_q;
`endif
  assign busy    = busy_q;
  assign tone_id = tone_id_q;
  assign done    = done_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Self-checking bench for buzzer_sequencer: directed scenarios plus random requests against a
// pattern-elapsed-time reference model.
module tb_buzzer_sequencer;

  localparam int CH = 2;
  localparam int CL = 12;
  localparam int PH = 1;
  localparam int PL = 8;
  localparam int FH = 2;
  localparam int FS = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_click, req_pass, req_fail;
  logic       mute;
  logic       buzzer, busy, done;
  logic [1:0] tone_id;

  int tests = 0;
  int fails = 0;

  // Model: kind of pattern playing (0 idle, 1 click, 2 pass, 3 fail) and index of current cycle.
  int   m_kind;
  int   m_e;
  logic m_done;

  buzzer_sequencer #(
    .CLICK_HALF(CH), .CLICK_LEN(CL), .PASS_HALF(PH), .PASS_LEN(PL),
    .FAIL_HALF(FH), .FAIL_SEG(FS), .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_click(req_click),
    .req_pass (req_pass),
    .req_fail (req_fail),
`ifdef BUZZER_MUTE_EN
    .mute     (mute),
`endif
    .buzzer   (buzzer),
    .busy     (busy),
    .tone_id  (tone_id),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int pat_len(input int k);
    case (k)
      1:       return CL;
      2:       return PL;
      3:       return 3 * FS;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_buzz(input int k, input int e);
    int seg;
    case (k)
      1: return ((e / CH) % 2) == 0;
      2: return ((e / PH) % 2) == 0;
      3: begin
        seg = e / FS;
        if (seg == 1) return 1'b0;
        return (((e % FS) / FH) % 2) == 0;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input logic rc, input logic rp, input logic rf);
    int  rpri;
    int  cur;
    logic fin;
    rpri = rf ? 3 : (rp ? 2 : (rc ? 1 : 0));
    fin  = (m_kind != 0) && (m_e == pat_len(m_kind) - 1);
    cur  = fin ? 0 : m_kind;
    m_done = 1'b0;
    if (rpri != 0 && rpri >= cur) begin
      m_kind = rpri;
      m_e    = 0;
    end else if (fin) begin
      m_kind = 0;
      m_e    = 0;
      m_done = 1'b1;
    end else if (m_kind != 0) begin
      m_e++;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic eb;
    eb = exp_buzz(m_kind, m_e);
`ifdef BUZZER_MUTE_EN
    eb = eb & ~mute;
`endif
    chk("buzzer", {1'b0, buzzer}, {1'b0, eb});
    chk("busy", {1'b0, busy}, {1'b0, m_kind != 0});
    chk("tone_id", tone_id, 2'(m_kind));
    chk("done", {1'b0, done}, {1'b0, m_done});
  endtask

  task automatic step(input logic rc, input logic rp, input logic rf);
    req_click = rc;
    req_pass  = rp;
    req_fail  = rf;
    @(posedge clk);
    model_edge(rc, rp, rf);
    #1;
    req_click = 1'b0;
    req_pass  = 1'b0;
    req_fail  = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req_click = 1'b0;
    req_pass  = 1'b0;
    req_fail  = 1'b0;
    mute      = 1'b0;
    m_kind = 0;
    m_e    = 0;
    m_done = 1'b0;
    #12;
    check_all();
    rst = 1'b0;
    idle(2);

    // Click: three 1,1,0,0 periods then done.
    step(1'b1, 1'b0, 1'b0);
    idle(14);

    // Fail: beep / gap / beep.
    step(1'b0, 1'b0, 1'b1);
    idle(20);

    // Pass pre-empts click; click during pass is ignored.
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(6);

    // Simultaneous requests, then fail retrigger at cycle 8.
    step(1'b1, 1'b1, 1'b1);
    idle(7);
    step(1'b0, 1'b0, 1'b1);
    idle(20);

    // Lower-priority request on the completing edge is accepted without done.
    step(1'b0, 1'b1, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 1'b0);
    idle(13);

    // Asynchronous reset mid-pass.
    step(1'b0, 1'b1, 1'b0);
    idle(4);
    #2;
    rst = 1'b1;
    m_kind = 0;
    m_e    = 0;
    m_done = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2;
    rst = 1'b0;
    idle(6);

`ifdef BUZZER_MUTE_EN
    // Mute during click cycles 3..6.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 14; i++) begin
      mute = (i >= 3 && i <= 6);
      step(1'b0, 1'b0, 1'b0);
    end
    mute = 1'b0;
`endif

    // Random request traffic.
    for (int i = 0; i < 400; i++) begin
`ifdef BUZZER_MUTE_EN
      mute = ($urandom_range(0, 7) == 0);
`endif
      step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
